// File: rtl/mem_stage_bus.sv
// mem_stage_bus: pipeline MEM stage. Non-memory ops pass straight through to
// MEM/WB. Loads and stores run one Wishbone classic single transfer and apply
// big-endian lane alignment. stallreq holds the pipeline while a transfer is
// outstanding.
module mem_stage_bus #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stallreq,
  output logic              adel_o,
  output logic              ades_o
);

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;

  state_t            state, state_nx;
  logic              is_load, is_store, is_byte, is_half, is_mem;
  logic              misaligned, mem_go;
  logic [3:0]        lane_sel;
  logic [DATA_W-1:0] store_data, load_word, load_result, rd_buf;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic              stall_unused;

  // Only the EX/MEM hold bit of the CTRL stall vector matters here.
  assign stall_unused = ^{stall[5:4], stall[2:0]};

  // Decode the op into access class and size.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    case (aluop_i)
      OP_LB, OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
      OP_LW:         is_load  = 1'b1;
      OP_SB:         begin is_store = 1'b1; is_byte = 1'b1; end
      OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:         is_store = 1'b1;
      default:       ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign misaligned = (is_half & mem_addr_i[0]) |
                      (is_mem & ~is_byte & ~is_half & (mem_addr_i[1:0] != 2'b00));
  assign mem_go     = is_mem & ~misaligned & ~flush;

  // Big-endian lane select and replicated store data.
  always_comb begin
    lane_sel   = 4'b1111;
    store_data = reg2_i;
    if (is_byte) begin
      lane_sel   = 4'b1000 >> mem_addr_i[1:0];
      store_data = {4{reg2_i[7:0]}};
    end else if (is_half) begin
      lane_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      store_data = {2{reg2_i[15:0]}};
    end
  end

  // Extract and extend the load lane from the live bus data or the read buffer.
  always_comb begin
    load_word = (state == HOLD) ? rd_buf : wb_dat_i;
    case (mem_addr_i[1:0])
      2'd0:    byte_lane = load_word[31:24];
      2'd1:    byte_lane = load_word[23:16];
      2'd2:    byte_lane = load_word[15:8];
      default: byte_lane = load_word[7:0];
    endcase
    half_lane = mem_addr_i[1] ? load_word[15:0] : load_word[31:16];
    case (aluop_i)
      OP_LB:   load_result = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  load_result = {24'd0, byte_lane};
      OP_LH:   load_result = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_result = {16'd0, half_lane};
      default: load_result = load_word;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; a started transfer always runs to its ack.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (mem_go) state_nx = BUSY;
      BUSY: begin
        if (wb_ack_i)   state_nx = (stall[3] && !flush) ? HOLD : IDLE;
        else if (flush) state_nx = DRAIN;
      end
      HOLD:  if (!stall[3] || flush) state_nx = IDLE;
      DRAIN: if (wb_ack_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Writeback fields, error flags and stall request; all forced low in reset.
  always_comb begin
    wd_o     = 5'd0;
    wreg_o   = 1'b0;
    wdata_o  = '0;
    stallreq = 1'b0;
    adel_o   = 1'b0;
    ades_o   = 1'b0;
    if (rst) begin
      wd_o    = wd_i;
      wdata_o = is_load ? load_result : wdata_i;
      case (state)
        IDLE: begin
          if (!is_mem || flush) begin
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end else if (misaligned) begin
            adel_o = is_load;
            ades_o = is_store;
          end else begin
            stallreq = 1'b1;
          end
        end
        BUSY: begin
          if (wb_ack_i) wreg_o   = wreg_i & is_load & ~flush;
          else          stallreq = 1'b1;
        end
        HOLD:    wreg_o   = wreg_i & is_load & ~flush;
        DRAIN:   stallreq = 1'b1;
        default: ;
      endcase
    end
  end

  // Bus master registers and read buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= 4'd0;
      wb_we_o  <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      rd_buf   <= '0;
    end else if (state == IDLE && mem_go) begin
      wb_adr_o <= {mem_addr_i[ADDR_W-1:2], 2'b00};
      wb_dat_o <= store_data;
      wb_sel_o <= lane_sel;
      wb_we_o  <= is_store;
      wb_stb_o <= 1'b1;
      wb_cyc_o <= 1'b1;
    end else if (wb_ack_i && (state == BUSY || state == DRAIN)) begin
      wb_we_o  <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      if (state == BUSY) rd_buf <= wb_dat_i;
    end
  end

endmodule

// File: tb/tb_mem_stage_bus.sv
// tb_mem_stage_bus: directed tests for the MEM stage with a hand-driven bus slave.
module tb_mem_stage_bus;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd;
  logic        wreg;
  logic [31:0] wdata, mem_addr, reg2, wb_dat_i;
  logic [7:0]  aluop;
  logic [5:0]  stall;
  logic        flush, wb_ack_i;
  logic [31:0] wb_adr_o, wb_dat_o, wdata_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wreg_o, stallreq, adel_o, ades_o;
  logic [4:0]  wd_o;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] word;
    logic [3:0]  sel;
    logic [31:0] res;
  } ld_vec_t;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] r2;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] adr;
  } st_vec_t;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [1:0]  err;  // {adel, ades}
  } mis_vec_t;

  ld_vec_t ld_tab [7] = '{
    '{OP_LB,  32'h101, 32'h12F45678, 4'b0100, 32'hFFFFFFF4},
    '{OP_LBU, 32'h101, 32'h12F45678, 4'b0100, 32'h000000F4},
    '{OP_LB,  32'h100, 32'h7F000080, 4'b1000, 32'h0000007F},
    '{OP_LH,  32'h102, 32'h12348001, 4'b0011, 32'hFFFF8001},
    '{OP_LHU, 32'h100, 32'h92345678, 4'b1100, 32'h00009234},
    '{OP_LBU, 32'h103, 32'h000000FF, 4'b0001, 32'h000000FF},
    '{OP_LW,  32'h108, 32'h89ABCDEF, 4'b1111, 32'h89ABCDEF}
  };

  st_vec_t st_tab [5] = '{
    '{OP_SH, 32'h202, 32'h0000ABCD, 4'b0011, 32'hABCDABCD, 32'h200},
    '{OP_SB, 32'h203, 32'h123456A5, 4'b0001, 32'hA5A5A5A5, 32'h200},
    '{OP_SB, 32'h100, 32'h00000012, 4'b1000, 32'h12121212, 32'h100},
    '{OP_SH, 32'h100, 32'hFFFF1234, 4'b1100, 32'h12341234, 32'h100},
    '{OP_SW, 32'h30C, 32'hCAFEBABE, 4'b1111, 32'hCAFEBABE, 32'h30C}
  };

  mis_vec_t mis_tab [6] = '{
    '{OP_LW,  32'h102, 2'b10},
    '{OP_LW,  32'h101, 2'b10},
    '{OP_LH,  32'h103, 2'b10},
    '{OP_LHU, 32'h101, 2'b10},
    '{OP_SH,  32'h201, 2'b01},
    '{OP_SW,  32'h203, 2'b01}
  };

  mem_stage_bus dut (
    .clk(clk), .rst(rst), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata),
    .aluop_i(aluop), .mem_addr_i(mem_addr), .reg2_i(reg2), .stall(stall),
    .flush(flush), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq(stallreq),
    .adel_o(adel_o), .ades_o(ades_o)
  );

  always #5 clk = ~clk;

  task automatic set_nop();
    aluop = OP_NOP; wd = 5'd0; wreg = 1'b0; wdata = 32'd0; mem_addr = 32'd0;
    reg2 = 32'd0; flush = 1'b0; stall = 6'd0; wb_ack_i = 1'b0; wb_dat_i = 32'd0;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] r2, input logic [4:0] dst, input logic we);
    aluop = op; mem_addr = addr; reg2 = r2; wd = dst; wreg = we; wdata = 32'h0BAD_0BAD;
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Minimal two-cycle access (ack in the first BUSY cycle); returns what was seen on the ack cycle.
  task automatic access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                        input logic [31:0] word, output logic [3:0] sel, output logic we,
                        output logic [31:0] dat, output logic [31:0] adr, output logic wr,
                        output logic [31:0] wdat);
    set_op(op, addr, r2, 5'd4, 1'b1);
    step();
    wb_ack_i = 1'b1; wb_dat_i = word;
    @(negedge clk);
    sel = wb_sel_o; we = wb_we_o; dat = wb_dat_o; adr = wb_adr_o; wr = wreg_o; wdat = wdata_o;
    step();
    set_nop();
    @(negedge clk);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_op(OP_LW, 32'h104, 32'h1357, 5'd7, 1'b1);
    wdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    tests_run++; if ({wd_o, wreg_o, stallreq, adel_o, ades_o} !== 9'd0) begin tests_failed++;
      $display("FAIL reset_ctl: got %h expected 0", {wd_o, wreg_o, stallreq, adel_o, ades_o}); end
    tests_run++; if (wdata_o !== 32'd0) begin tests_failed++;
      $display("FAIL reset_wdata: got %h expected 0", wdata_o); end
    tests_run++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'd0) begin tests_failed++;
      $display("FAIL reset_bus_ctl: got %b expected 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); end
    tests_run++; if ({wb_adr_o, wb_dat_o} !== 64'd0) begin tests_failed++;
      $display("FAIL reset_bus_data: got %h expected 0", {wb_adr_o, wb_dat_o}); end
    set_nop();
    rst = 1'b1;
    step();
  endtask

  task automatic test_passthrough();
    aluop = 8'h21; wd = 5'd3; wreg = 1'b1; wdata = 32'hA5A5_0001;
    @(negedge clk);
    tests_run++; if ({wd_o, wreg_o, stallreq} !== {5'd3, 1'b1, 1'b0}) begin tests_failed++;
      $display("FAIL pass_ctl: got %h expected %h", {wd_o, wreg_o, stallreq}, {5'd3, 1'b1, 1'b0}); end
    tests_run++; if (wdata_o !== 32'hA5A5_0001) begin tests_failed++;
      $display("FAIL pass_wdata: got %h expected a5a50001", wdata_o); end
    step();
    tests_run++; if (wb_cyc_o !== 1'b0) begin tests_failed++;
      $display("FAIL pass_nobus: got %b expected 0", wb_cyc_o); end
    set_nop();
  endtask

  task automatic test_lw();
    int stall_cycles = 0;
    set_op(OP_LW, 32'h0000_0104, 32'd0, 5'd9, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin wb_ack_i = 1'b1; wb_dat_i = 32'hDEADBEEF; end
      @(negedge clk);
      if (stallreq === 1'b1) stall_cycles++;
      if (c == 1) begin
        tests_run++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b1101111) begin tests_failed++;
          $display("FAIL lw_bus_ctl: got %b expected 1101111", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); end
        tests_run++; if (wb_adr_o !== 32'h104) begin tests_failed++;
          $display("FAIL lw_adr: got %h expected 00000104", wb_adr_o); end
      end
      if (c == 4) begin
        tests_run++; if ({wd_o, wreg_o} !== {5'd9, 1'b1}) begin tests_failed++;
          $display("FAIL lw_wreg: got %h expected %h", {wd_o, wreg_o}, {5'd9, 1'b1}); end
        tests_run++; if (wdata_o !== 32'hDEADBEEF) begin tests_failed++;
          $display("FAIL lw_wdata: got %h expected deadbeef", wdata_o); end
      end
      step();
    end
    set_nop();
    @(negedge clk);
    tests_run++; if (stall_cycles !== 4) begin tests_failed++;
      $display("FAIL lw_stall_cycles: got %0d expected 4", stall_cycles); end
    tests_run++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin tests_failed++;
      $display("FAIL lw_cyc_drop: got %b expected 00", {wb_cyc_o, wb_stb_o}); end
    step();
  endtask

  task automatic test_load_align();
    logic [3:0] sel; logic we, wr; logic [31:0] dat, adr, wdat;
    for (int i = 0; i < 7; i++) begin
      access(ld_tab[i].op, ld_tab[i].addr, 32'd0, ld_tab[i].word, sel, we, dat, adr, wr, wdat);
      tests_run++; if ({sel, we, wr} !== {ld_tab[i].sel, 1'b0, 1'b1}) begin tests_failed++;
        $display("FAIL load_sel[%0d]: got %b expected %b", i, {sel, we, wr}, {ld_tab[i].sel, 1'b0, 1'b1}); end
      tests_run++; if (wdat !== ld_tab[i].res) begin tests_failed++;
        $display("FAIL load_data[%0d]: got %h expected %h", i, wdat, ld_tab[i].res); end
    end
  endtask

  task automatic test_store();
    logic [3:0] sel; logic we, wr; logic [31:0] dat, adr, wdat;
    for (int i = 0; i < 5; i++) begin
      access(st_tab[i].op, st_tab[i].addr, st_tab[i].r2, 32'hFFFF_FFFF, sel, we, dat, adr, wr, wdat);
      tests_run++; if ({sel, we, wr} !== {st_tab[i].sel, 1'b1, 1'b0}) begin tests_failed++;
        $display("FAIL store_ctl[%0d]: got %b expected %b", i, {sel, we, wr}, {st_tab[i].sel, 1'b1, 1'b0}); end
      tests_run++; if ({dat, adr} !== {st_tab[i].dat, st_tab[i].adr}) begin tests_failed++;
        $display("FAIL store_bus[%0d]: got %h expected %h", i, {dat, adr}, {st_tab[i].dat, st_tab[i].adr}); end
    end
  endtask

  task automatic test_misaligned();
    logic cyc_seen;
    for (int i = 0; i < 6; i++) begin
      set_op(mis_tab[i].op, mis_tab[i].addr, 32'd0, 5'd2, 1'b1);
      @(negedge clk);
      cyc_seen = wb_cyc_o;
      tests_run++; if ({adel_o, ades_o, wreg_o, stallreq} !== {mis_tab[i].err, 2'b00}) begin tests_failed++;
        $display("FAIL misalign_flags[%0d]: got %b expected %b", i, {adel_o, ades_o, wreg_o, stallreq},
                 {mis_tab[i].err, 2'b00}); end
      step();
      @(negedge clk);
      cyc_seen |= wb_cyc_o;
      step();
      set_nop();
      @(negedge clk);
      cyc_seen |= wb_cyc_o;
      tests_run++; if (cyc_seen !== 1'b0) begin tests_failed++;
        $display("FAIL misalign_nobus[%0d]: got %b expected 0", i, cyc_seen); end
      step();
    end
  endtask

  task automatic test_hold();
    logic cyc_seen = 1'b0;
    set_op(OP_LW, 32'h300, 32'd0, 5'd11, 1'b1);
    stall = 6'b001111;
    @(negedge clk);
    step();
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
    @(negedge clk);
    tests_run++; if ({wdata_o, wreg_o, stallreq} !== {32'hCAFE_F00D, 1'b1, 1'b0}) begin tests_failed++;
      $display("FAIL hold_ack: got %h expected %h", {wdata_o, wreg_o, stallreq}, {32'hCAFE_F00D, 1'b1, 1'b0}); end
    step();
    wb_ack_i = 1'b0; wb_dat_i = 32'h1111_1111;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) stall = 6'd0;
      @(negedge clk);
      cyc_seen |= wb_cyc_o;
      tests_run++; if ({wdata_o, wreg_o, stallreq} !== {32'hCAFE_F00D, 1'b1, 1'b0}) begin tests_failed++;
        $display("FAIL hold_buf[%0d]: got %h expected %h", c, {wdata_o, wreg_o, stallreq},
                 {32'hCAFE_F00D, 1'b1, 1'b0}); end
      step();
    end
    tests_run++; if (cyc_seen !== 1'b0) begin tests_failed++;
      $display("FAIL hold_no_reissue: got %b expected 0", cyc_seen); end
    // A fresh load right after HOLD must start from IDLE.
    set_op(OP_LW, 32'h304, 32'd0, 5'd12, 1'b1);
    @(negedge clk);
    tests_run++; if (stallreq !== 1'b1) begin tests_failed++;
      $display("FAIL hold_exit_idle: got %b expected 1", stallreq); end
    step();
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0042;
    @(negedge clk);
    tests_run++; if (wdata_o !== 32'h0000_0042) begin tests_failed++;
      $display("FAIL hold_next_load: got %h expected 00000042", wdata_o); end
    step();
    set_nop();
    @(negedge clk);
    step();
  endtask

  task automatic test_drain();
    set_op(OP_LW, 32'h400, 32'd0, 5'd12, 1'b1);
    @(negedge clk);
    step();
    flush = 1'b1;
    @(negedge clk);
    tests_run++; if ({wb_cyc_o, stallreq, wreg_o} !== 3'b110) begin tests_failed++;
      $display("FAIL drain_flush: got %b expected 110", {wb_cyc_o, stallreq, wreg_o}); end
    step();
    set_nop(); wreg = 1'b1; wdata = 32'h55;
    for (int c = 0; c < 2; c++) begin
      if (c == 1) begin wb_ack_i = 1'b1; wb_dat_i = 32'h7777_7777; end
      @(negedge clk);
      tests_run++; if ({wb_cyc_o, wb_stb_o, stallreq, wreg_o} !== 4'b1110) begin tests_failed++;
        $display("FAIL drain_hold[%0d]: got %b expected 1110", c, {wb_cyc_o, wb_stb_o, stallreq, wreg_o}); end
      step();
    end
    wb_ack_i = 1'b0;
    @(negedge clk);
    tests_run++; if ({wb_cyc_o, stallreq, wreg_o, wdata_o} !== {3'b001, 32'h55}) begin tests_failed++;
      $display("FAIL drain_idle: got %h expected %h", {wb_cyc_o, stallreq, wreg_o, wdata_o}, {3'b001, 32'h55}); end
    step();
    set_nop();
  endtask

  task automatic test_flush_cases();
    // Flush coinciding with ack: transfer completes, result dropped.
    set_op(OP_LW, 32'h500, 32'd0, 5'd13, 1'b1);
    @(negedge clk);
    step();
    wb_ack_i = 1'b1; wb_dat_i = 32'h9999_9999; flush = 1'b1;
    @(negedge clk);
    tests_run++; if ({wreg_o, stallreq} !== 2'b00) begin tests_failed++;
      $display("FAIL flush_ack: got %b expected 00", {wreg_o, stallreq}); end
    step();
    set_nop();
    @(negedge clk);
    tests_run++; if ({wb_cyc_o, stallreq} !== 2'b00) begin tests_failed++;
      $display("FAIL flush_ack_idle: got %b expected 00", {wb_cyc_o, stallreq}); end
    step();
    // Flush in IDLE: behaves as a non-memory op.
    set_op(OP_LW, 32'h600, 32'd0, 5'd14, 1'b1);
    wdata = 32'h6666_6666; flush = 1'b1;
    @(negedge clk);
    tests_run++; if ({stallreq, wreg_o, wdata_o} !== {2'b01, 32'h6666_6666}) begin tests_failed++;
      $display("FAIL flush_idle: got %h expected %h", {stallreq, wreg_o, wdata_o}, {2'b01, 32'h6666_6666}); end
    step();
    set_nop();
    @(negedge clk);
    tests_run++; if (wb_cyc_o !== 1'b0) begin tests_failed++;
      $display("FAIL flush_idle_nobus: got %b expected 0", wb_cyc_o); end
    step();
  endtask

  task automatic test_reset_mid();
    set_op(OP_LW, 32'h700, 32'h1357, 5'd7, 1'b1);
    @(negedge clk);
    step();
    #2;
    tests_run++; if (wb_cyc_o !== 1'b1) begin tests_failed++;
      $display("FAIL rstmid_busy: got %b expected 1", wb_cyc_o); end
    rst = 1'b0;
    #1;
    tests_run++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !== 71'd0) begin tests_failed++;
      $display("FAIL rstmid_bus: got %h expected 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}); end
    tests_run++; if ({wd_o, wreg_o, stallreq, wdata_o} !== 39'd0) begin tests_failed++;
      $display("FAIL rstmid_wb: got %h expected 0", {wd_o, wreg_o, stallreq, wdata_o}); end
    set_nop();
    @(negedge clk);
    rst = 1'b1;
    step();
    @(negedge clk);
    tests_run++; if ({wb_cyc_o, stallreq} !== 2'b00) begin tests_failed++;
      $display("FAIL rstmid_after: got %b expected 00", {wb_cyc_o, stallreq}); end
    step();
  endtask

  initial begin
    set_nop();
    test_reset();
    test_passthrough();
    test_lw();
    test_load_align();
    test_store();
    test_misaligned();
    test_hold();
    test_drain();
    test_flush_cases();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
